// File: rtl/prince_mask_pkg.sv
// Shared constants, state encoding and nibble helpers for the masked PRINCE S-box sequencer.
package prince_mask_pkg;

   localparam int NIBBLES = 16;
   localparam int NIB_W   = 4;
   localparam int SHARE_W = NIBBLES * NIB_W;
   localparam int IDX_W   = 4;

   typedef logic [NIB_W-1:0] nibble_t;
   typedef logic [IDX_W-1:0] nib_idx_t;

   localparam nib_idx_t LAST_IDX = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   function automatic nibble_t get_nibble(input logic [SHARE_W-1:0] share, input nib_idx_t idx);
      return share[{idx, 2'b00} +: NIB_W];
   endfunction

   function automatic logic [SHARE_W-1:0] put_nibble(input logic [SHARE_W-1:0] share,
                                                     input nib_idx_t idx, input nibble_t val);
      logic [SHARE_W-1:0] res;
      res = share;
      res[{idx, 2'b00} +: NIB_W] = val;
      return res;
   endfunction

endpackage

// File: rtl/prince_sbox_tag_pipe.sv
// Valid/index delay line that tracks nibbles in flight through the masked S-box pipeline.
module prince_sbox_tag_pipe
   import prince_mask_pkg::*;
#(
   parameter int SBOX_LAT = 3
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx,
   output logic             tail_valid,
   output logic [IDX_W-1:0] tail_idx,
   output logic             inflight
);

   logic [SBOX_LAT-1:0] valid_r;
   nib_idx_t            idx_r [SBOX_LAT];

   // Shift tags one stage per cycle; the S-box cannot stall, so neither can this.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {SBOX_LAT{1'b0}};
         for (int i = 0; i < SBOX_LAT; i++) begin
            idx_r[i] <= 4'd0;
         end
      end else begin
         valid_r[0] <= in_valid;
         idx_r[0]   <= in_idx;
         for (int i = 1; i < SBOX_LAT; i++) begin
            valid_r[i] <= valid_r[i-1];
            idx_r[i]   <= idx_r[i-1];
         end
      end
   end

   // Any tag not yet at the tail means a result is still to come.
   always_comb begin
      inflight = 1'b0;
      for (int i = 0; i < SBOX_LAT - 1; i++) begin
         inflight = inflight | valid_r[i];
      end
   end

   assign tail_valid = valid_r[SBOX_LAT-1];
   assign tail_idx   = idx_r[SBOX_LAT-1];

endmodule

// File: rtl/prince_sbox_seq.sv
// Sequencer feeding one nibble per cycle into the shared 3-share masked PRINCE S-box.
// Optional fresh-randomness handshake is enabled with `define PRINCE_REMASK_EN.
module prince_sbox_seq
   import prince_mask_pkg::*;
#(
   parameter int SBOX_LAT = 3
`ifdef PRINCE_REMASK_EN
   , parameter int RND_W = 12
`endif
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [SHARE_W-1:0] state_in_a,
   input  logic [SHARE_W-1:0] state_in_b,
   input  logic [SHARE_W-1:0] state_in_c,
   output logic               busy,
   output logic               done,
   output logic [SHARE_W-1:0] state_out_a,
   output logic [SHARE_W-1:0] state_out_b,
   output logic [SHARE_W-1:0] state_out_c,
   output logic               sb_in_valid,
   output logic [NIB_W-1:0]   sb_in_a,
   output logic [NIB_W-1:0]   sb_in_b,
   output logic [NIB_W-1:0]   sb_in_c,
`ifdef PRINCE_REMASK_EN
   input  logic [RND_W-1:0]   rnd_in,
   input  logic               rnd_valid,
   output logic               rnd_ready,
   output logic [RND_W-1:0]   sb_rnd,
`endif
   input  logic [NIB_W-1:0]   sb_out_a,
   input  logic [NIB_W-1:0]   sb_out_b,
   input  logic [NIB_W-1:0]   sb_out_c
);

   seq_state_e         state_r;
   nib_idx_t           idx_r;
   logic [SHARE_W-1:0] work_a_r, work_b_r, work_c_r;
   logic [SHARE_W-1:0] work_a_s, work_b_s, work_c_s;
   logic               issue_ok_s;
   logic               issue_s;
   logic               tail_valid_s;
   nib_idx_t           tail_idx_s;
   logic               inflight_s;
   logic               drain_done_s;

`ifdef PRINCE_REMASK_EN
   assign issue_ok_s = rnd_valid;
   assign rnd_ready  = (state_r == ST_ISSUE);
   assign sb_rnd     = issue_s ? rnd_in : {RND_W{1'b0}};
`else
   assign issue_ok_s = 1'b1;
`endif

   // Issue decode; each share has its own nibble mux and is forced to zero when idle.
   always_comb begin
      issue_s = 1'b0;
      sb_in_a = 4'd0;
      sb_in_b = 4'd0;
      sb_in_c = 4'd0;
      if ((state_r == ST_ISSUE) && issue_ok_s) begin
         issue_s = 1'b1;
         sb_in_a = get_nibble(work_a_r, idx_r);
         sb_in_b = get_nibble(work_b_r, idx_r);
         sb_in_c = get_nibble(work_c_r, idx_r);
      end else begin
         issue_s = 1'b0;
         sb_in_a = 4'd0;
         sb_in_b = 4'd0;
         sb_in_c = 4'd0;
      end
   end

   assign sb_in_valid = issue_s;

   prince_sbox_tag_pipe #(
      .SBOX_LAT (SBOX_LAT)
   ) u_tag_pipe (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (issue_s),
      .in_idx     (idx_r),
      .tail_valid (tail_valid_s),
      .tail_idx   (tail_idx_s),
      .inflight   (inflight_s)
   );

   // Merge the returning S-box nibble into its slot, share by share.
   always_comb begin
      work_a_s = work_a_r;
      work_b_s = work_b_r;
      work_c_s = work_c_r;
      if (tail_valid_s) begin
         work_a_s = put_nibble(work_a_r, tail_idx_s, sb_out_a);
         work_b_s = put_nibble(work_b_r, tail_idx_s, sb_out_b);
         work_c_s = put_nibble(work_c_r, tail_idx_s, sb_out_c);
      end else begin
         work_a_s = work_a_r;
         work_b_s = work_b_r;
         work_c_s = work_c_r;
      end
   end

   assign drain_done_s = (state_r == ST_DRAIN) && !inflight_s;

   // Working shares load on start; published shares capture the final write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_a_r    <= 64'd0;
         work_b_r    <= 64'd0;
         work_c_r    <= 64'd0;
         state_out_a <= 64'd0;
         state_out_b <= 64'd0;
         state_out_c <= 64'd0;
      end else if ((state_r == ST_IDLE) && start) begin
         work_a_r <= state_in_a;
         work_b_r <= state_in_b;
         work_c_r <= state_in_c;
      end else begin
         work_a_r <= work_a_s;
         work_b_r <= work_b_s;
         work_c_r <= work_c_s;
         if (drain_done_s) begin
            state_out_a <= work_a_s;
            state_out_b <= work_b_s;
            state_out_c <= work_c_s;
         end
      end
   end

   // Control FSM with registered busy/done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         idx_r   <= 4'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r <= ST_ISSUE;
                  idx_r   <= 4'd0;
                  busy    <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (issue_s) begin
                  idx_r <= idx_r + 4'd1;
                  if (idx_r == LAST_IDX) begin
                     state_r <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_done_s) begin
                  state_r <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prince_sbox_seq.sv
// Scoreboard bench for prince_sbox_seq at S-box latencies 3, 1 and 8 side by side.
module tb_prince_sbox_seq;

   localparam int NDUT = 3;
   localparam logic [63:0] X1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] Y1 = 64'hBF32AC916780E5D4;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 3;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hB;  4'h1: return 4'hF;  4'h2: return 4'h3;  4'h3: return 4'h2;
         4'h4: return 4'hA;  4'h5: return 4'hC;  4'h6: return 4'h9;  4'h7: return 4'h1;
         4'h8: return 4'h6;  4'h9: return 4'h7;  4'hA: return 4'h8;  4'hB: return 4'h0;
         4'hC: return 4'hE;  4'hD: return 4'h5;  4'hE: return 4'hD;  default: return 4'h4;
      endcase
   endfunction

   // Share-wise model: output shares b and c pass through, share a absorbs the correction.
   function automatic logic [11:0] sbox_shared(input logic [3:0] a, b, c);
      logic [3:0] s;
      s = sbox(a ^ b ^ c);
      return {s ^ b ^ c, b, c};
   endfunction

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] in_a = 64'd0, in_b = 64'd0, in_c = 64'd0;
   logic        busy_v [NDUT];
   logic        done_v [NDUT];
   logic        sbv_v  [NDUT];
   logic [63:0] oa [NDUT], ob [NDUT], oc [NDUT];
   logic [3:0]  sia [NDUT], sib [NDUT], sic [NDUT];
   logic [3:0]  soa [NDUT], sob [NDUT], soc [NDUT];
   logic [11:0] mdl_pipe [NDUT][8];
`ifdef PRINCE_REMASK_EN
   logic [11:0] rnd_in = 12'h123;
   logic        rnd_valid = 1'b1;
   logic        rr_v [NDUT];
   logic [11:0] srnd [NDUT];
`endif

   int cyc = 0;
   int st0 = -1, st1 = -1;
   int n_chk = 0, n_pass = 0;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      int          cyc;
   } exp_t;
   exp_t exp_q [NDUT][$];

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      prince_sbox_seq #(.SBOX_LAT(lat_of(k))) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .start       (start),
         .state_in_a  (in_a),
         .state_in_b  (in_b),
         .state_in_c  (in_c),
         .busy        (busy_v[k]),
         .done        (done_v[k]),
         .state_out_a (oa[k]),
         .state_out_b (ob[k]),
         .state_out_c (oc[k]),
         .sb_in_valid (sbv_v[k]),
         .sb_in_a     (sia[k]),
         .sb_in_b     (sib[k]),
         .sb_in_c     (sic[k]),
`ifdef PRINCE_REMASK_EN
         .rnd_in      (rnd_in),
         .rnd_valid   (rnd_valid),
         .rnd_ready   (rr_v[k]),
         .sb_rnd      (srnd[k]),
`endif
         .sb_out_a    (soa[k]),
         .sb_out_b    (sob[k]),
         .sb_out_c    (soc[k])
      );
   end

   // Pipelined S-box models, one per latency.
   always @(posedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         for (int j = 7; j > 0; j--) mdl_pipe[k][j] <= mdl_pipe[k][j-1];
         mdl_pipe[k][0] <= sbox_shared(sia[k], sib[k], sic[k]);
      end
   end

   always_comb begin
      for (int k = 0; k < NDUT; k++) begin
         {soa[k], sob[k], soc[k]} = mdl_pipe[k][lat_of(k)-1];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // Monitor: pops the oldest expectation on every done pulse, plus idle-bus checks.
   always @(negedge clk) begin : monitor
      exp_t e;
      for (int k = 0; k < NDUT; k++) begin
         if (done_v[k] === 1'b1) begin
            if (exp_q[k].size() == 0) begin
               chk($sformatf("dut%0d unexpected done", k), 64'(done_v[k]), 64'd0);
            end else begin
               e = exp_q[k].pop_front();
               chk($sformatf("dut%0d out_a", k), oa[k], e.a);
               chk($sformatf("dut%0d out_b", k), ob[k], e.b);
               chk($sformatf("dut%0d out_c", k), oc[k], e.c);
               chk($sformatf("dut%0d out xor", k), oa[k] ^ ob[k] ^ oc[k], e.a ^ e.b ^ e.c);
               chk($sformatf("dut%0d done cycle", k), 64'(cyc), 64'(e.cyc));
               chk($sformatf("dut%0d busy at done", k), 64'(busy_v[k]), 64'd0);
            end
         end
         if (sbv_v[k] !== 1'b1) begin
            chk($sformatf("dut%0d sb_in idle zero", k), {52'd0, sia[k], sib[k], sic[k]}, 64'd0);
         end
`ifdef PRINCE_REMASK_EN
         if (sbv_v[k] === 1'b1) begin
            chk($sformatf("dut%0d sb_rnd fwd", k), 64'(srnd[k]), 64'(rnd_in));
            chk($sformatf("dut%0d rnd_ready issue", k), 64'(rr_v[k]), 64'd1);
         end else begin
            chk($sformatf("dut%0d sb_rnd idle", k), 64'(srnd[k]), 64'd0);
         end
         if (cyc == st0 || cyc == st1) begin
            chk($sformatf("dut%0d stall no issue", k), 64'(sbv_v[k]), 64'd0);
            chk($sformatf("dut%0d stall rnd_ready", k), 64'(rr_v[k]), 64'd1);
         end
`endif
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
`ifdef PRINCE_REMASK_EN
         rnd_valid = !(cyc == st0 || cyc == st1);
         rnd_in    = rnd_in + 12'h35B;
`endif
      end
   endtask

   task automatic launch(input logic [63:0] a, b, c, ea, eb, ec, input bit expect_done, input int extra);
      exp_t e;
      in_a  = a;
      in_b  = b;
      in_c  = c;
      start = 1'b1;
      if (expect_done) begin
         for (int k = 0; k < NDUT; k++) begin
            e.a = ea; e.b = eb; e.c = ec;
            e.cyc = cyc + 17 + lat_of(k) + extra;
            exp_q[k].push_back(e);
         end
      end
      step(1);
      start = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("%s dut%0d busy", tag, k), 64'(busy_v[k]), 64'd0);
         chk($sformatf("%s dut%0d done", tag, k), 64'(done_v[k]), 64'd0);
         chk($sformatf("%s dut%0d sb_in_valid", tag, k), 64'(sbv_v[k]), 64'd0);
         chk($sformatf("%s dut%0d out_a", tag, k), oa[k], 64'd0);
         chk($sformatf("%s dut%0d out_b", tag, k), ob[k], 64'd0);
         chk($sformatf("%s dut%0d out_c", tag, k), oc[k], 64'd0);
`ifdef PRINCE_REMASK_EN
         chk($sformatf("%s dut%0d rnd_ready", tag, k), 64'(rr_v[k]), 64'd0);
`endif
      end
   endtask

   initial begin
      logic [63:0] sb, sc;
      sb = 64'h5A5AC3C30F0F9669;
      sc = 64'h3C3C1234FEDC8001;

      step(3);
      @(negedge clk);
      chk_reset("por");
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(2);

      // Plain data in share a.
      launch(X1, 64'd0, 64'd0, Y1, 64'd0, 64'd0, 1'b1, 0);
      step(35);

      // Second start while busy must be ignored.
      launch(X1, 64'd0, 64'd0, Y1, 64'd0, 64'd0, 1'b1, 0);
      step(4);
      in_a  = 64'hFFFFFFFFFFFFFFFF;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(30);

      // Genuinely split shares.
      launch(X1 ^ sb ^ sc, sb, sc, Y1 ^ sb ^ sc, sb, sc, 1'b1, 0);
      step(35);

      // Reset in cycle 10 of a run: no done from it, outputs cleared.
      launch(X1 ^ sb, sb, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 0);
      step(9);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset("abort");
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(35);

      launch(X1, 64'd0, 64'd0, Y1, 64'd0, 64'd0, 1'b1, 0);
      step(35);

`ifdef PRINCE_REMASK_EN
      // Randomness withheld in cycles 3 and 7 of the run.
      st0 = cyc + 3;
      st1 = cyc + 7;
      launch(X1 ^ sc, 64'd0, sc, Y1 ^ sc, 64'd0, sc, 1'b1, 2);
      step(40);
      st0 = -1;
      st1 = -1;
`endif

      step(3);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("dut%0d missing done", k), 64'(exp_q[k].size()), 64'd0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
